trap_reservation_station: RTL and testbench

- Out-of-order scheduler in front of trap_unit. Buffers tw/twi operations from dispatch until both operands are available, snooping the common data bus (CDB) for pending operand tags.
- Issues ready entries to trap_unit over a valid/ready handshake, one per cycle, using round-robin selection.
- Each entry is identified downstream by rs_id = RS_OFFSET + entry index. The trap writeback is then matched back on that id.

---
 rtl/trap_reservation_station_pkg.sv | 55 +++++
 rtl/trap_reservation_station_if.sv | 48 ++++
 rtl/trap_reservation_station_rr_arbiter.sv | 32 +++
 rtl/trap_reservation_station.sv | 175 +++++++++++++++++
 tb/tb_trap_reservation_station.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/trap_reservation_station_pkg.sv
// Shared types for the trap-unit reservation station.
//   trap_decode_t   : decoded TO field carried with tw/twi operations.
//   trap_rs_entry_t : one buffered operation (busy, ready bits, values, tags, decode).
//   rr_select       : generic round-robin priority select, reusable by other stations.
package trap_reservation_station_pkg;

    // Tag fields in the entry struct are sized for the widest supported tag;
    // narrower producer tags are zero-extended on capture and comparison.
    localparam int unsigned RS_TAG_MAX_W = 16;
    localparam int unsigned RR_MAX_N     = 16;
    localparam int unsigned RR_IDX_W     = 4;

    typedef struct packed {
        logic [4:0] TO;
    } trap_decode_t;

    typedef struct packed {
        logic                    busy;
        logic                    op1_rdy;
        logic                    op2_rdy;
        logic [31:0]             op1_value;
        logic [31:0]             op2_value;
        logic [RS_TAG_MAX_W-1:0] op1_tag;
        logic [RS_TAG_MAX_W-1:0] op2_tag;
        trap_decode_t            control;
    } trap_rs_entry_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req[n-1:0] at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_select(input logic [RR_MAX_N-1:0] req,
                                           input logic [RR_IDX_W-1:0] ptr,
                                           input int unsigned         n);
        rr_pick_t    r;
        int unsigned slot;
        logic [31:0] slot_bits;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            if (!r.found && (k < n)) begin
                slot      = (32'(ptr) + k) % n;
                slot_bits = slot;
                if (req[slot_bits[RR_IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = slot_bits[RR_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/trap_reservation_station_if.sv
// Dispatch / CDB / issue bundle of the trap reservation station.
//   master : dispatch + CDB + flush + trap_unit ready (environment side)
//   slave  : the reservation station itself
interface trap_reservation_station_if #(
    parameter int unsigned RS_ID_WIDTH = 5
);
    import trap_reservation_station_pkg::*;

    // Dispatch side
    logic                   take_valid;
    logic                   take_ready;
    logic                   op1_valid;
    logic [31:0]            op1_value;
    logic [RS_ID_WIDTH-1:0] op1_rs_id;
    logic                   op2_valid;
    logic [31:0]            op2_value;
    logic [RS_ID_WIDTH-1:0] op2_rs_id;
    trap_decode_t           control;

    // Common data bus and pipeline flush
    logic                   cdb_valid;
    logic [RS_ID_WIDTH-1:0] cdb_rs_id;
    logic [31:0]            cdb_result;
    logic                   flush;

    // Issue side toward trap_unit
    logic                   issue_valid;
    logic                   issue_ready;
    logic [RS_ID_WIDTH-1:0] issue_rs_id;
    logic [31:0]            issue_op1;
    logic [31:0]            issue_op2;
    trap_decode_t           issue_control;

    modport master (
        output take_valid, op1_valid, op1_value, op1_rs_id,
               op2_valid, op2_value, op2_rs_id, control,
               cdb_valid, cdb_rs_id, cdb_result, flush, issue_ready,
        input  take_ready, issue_valid, issue_rs_id, issue_op1, issue_op2, issue_control
    );

    modport slave (
        input  take_valid, op1_valid, op1_value, op1_rs_id,
               op2_valid, op2_value, op2_rs_id, control,
               cdb_valid, cdb_rs_id, cdb_result, flush, issue_ready,
        output take_ready, issue_valid, issue_rs_id, issue_op1, issue_op2, issue_control
    );

endinterface

// File: rtl/trap_reservation_station_rr_arbiter.sv
// Round-robin arbiter shared by unit schedulers.
//   req_i   : N-wide request vector
//   ptr_i   : highest-priority index this cycle
//   grant_o : one-hot grant (all zero when nothing requests)
//   idx_o   : index of the granted request
module rr_arbiter
    import trap_reservation_station_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [RR_MAX_N-1:0] req_pad;
    rr_pick_t            pick;

    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req_i;
        pick           = rr_select(req_pad, RR_IDX_W'(ptr_i), N);
        idx_o          = IDX_W'(pick.idx);
        grant_o        = '0;
        if (pick.found) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/trap_reservation_station.sv
// Out-of-order scheduler in front of trap_unit.
// Buffers tw/twi operations until both operands are known (snooping the CDB),
// then issues ready entries one per cycle in round-robin order.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : dispatch (take_*/opN_*/control), CDB (cdb_*), flush, and the
//              issue_* handshake toward trap_unit; entry i is tagged RS_OFFSET+i
module trap_reservation_station
    import trap_reservation_station_pkg::*;
#(
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned ENTRIES     = 4,
    parameter int unsigned RS_OFFSET   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    trap_reservation_station_if.slave   bus
);

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    trap_rs_entry_t   entry_q [ENTRIES];
    trap_rs_entry_t   entry_d [ENTRIES];
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    logic [ENTRIES-1:0]    ready_vec;
    logic [ENTRIES-1:0]    arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  alloc_found;
    logic                  take_fire;
    logic                  issue_valid;
    logic                  issue_fire;
    logic [RS_TAG_MAX_W-1:0] cdb_tag;
    logic                  byp1, byp2;

    assign cdb_tag = RS_TAG_MAX_W'(bus.cdb_rs_id);

    always_comb begin
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            ready_vec[e] = entry_q[e].busy & entry_q[e].op1_rdy & entry_q[e].op2_rdy;
        end
    end

    // Lowest-index free entry, from registered busy bits only.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int unsigned e = ENTRIES; e > 0; e--) begin
            if (!entry_q[e-1].busy) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(e - 1);
            end
        end
    end

    rr_arbiter #(
        .N     (ENTRIES),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (ready_vec),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    // A stalled offer keeps its registered index so the outputs stay stable
    // even when a higher-priority entry becomes ready meanwhile.
    assign sel_idx     = lock_q ? lock_idx_q : arb_idx;
    assign issue_valid = lock_q | (|arb_grant);
    assign issue_fire  = issue_valid & bus.issue_ready;
    assign take_fire   = bus.take_valid & alloc_found & ~bus.flush;

    assign bus.take_ready = alloc_found;

    always_comb begin
        bus.issue_valid   = issue_valid;
        bus.issue_rs_id   = '0;
        bus.issue_op1     = '0;
        bus.issue_op2     = '0;
        bus.issue_control = '0;
        if (issue_valid) begin
            bus.issue_rs_id   = RS_ID_WIDTH'(RS_OFFSET + 32'(sel_idx));
            bus.issue_op1     = entry_q[sel_idx].op1_value;
            bus.issue_op2     = entry_q[sel_idx].op2_value;
            bus.issue_control = entry_q[sel_idx].control;
        end
    end

    assign byp1 = bus.cdb_valid && (RS_TAG_MAX_W'(bus.op1_rs_id) == cdb_tag);
    assign byp2 = bus.cdb_valid && (RS_TAG_MAX_W'(bus.op2_rs_id) == cdb_tag);

    // Priority within one edge: snoop, then issue release, then allocation
    // (only into an entry free before the edge), with flush overriding all.
    always_comb begin
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            entry_d[e] = entry_q[e];
        end

        if (bus.cdb_valid) begin
            for (int unsigned e = 0; e < ENTRIES; e++) begin
                if (entry_q[e].busy) begin
                    if (!entry_q[e].op1_rdy && (entry_q[e].op1_tag == cdb_tag)) begin
                        entry_d[e].op1_rdy   = 1'b1;
                        entry_d[e].op1_value = bus.cdb_result;
                    end
                    if (!entry_q[e].op2_rdy && (entry_q[e].op2_tag == cdb_tag)) begin
                        entry_d[e].op2_rdy   = 1'b1;
                        entry_d[e].op2_value = bus.cdb_result;
                    end
                end
            end
        end

        if (issue_fire) begin
            entry_d[sel_idx].busy = 1'b0;
        end

        if (take_fire) begin
            entry_d[alloc_idx].busy      = 1'b1;
            entry_d[alloc_idx].op1_rdy   = bus.op1_valid | byp1;
            entry_d[alloc_idx].op1_value = bus.op1_valid ? bus.op1_value : bus.cdb_result;
            entry_d[alloc_idx].op1_tag   = RS_TAG_MAX_W'(bus.op1_rs_id);
            entry_d[alloc_idx].op2_rdy   = bus.op2_valid | byp2;
            entry_d[alloc_idx].op2_value = bus.op2_valid ? bus.op2_value : bus.cdb_result;
            entry_d[alloc_idx].op2_tag   = RS_TAG_MAX_W'(bus.op2_rs_id);
            entry_d[alloc_idx].control   = bus.control;
        end

        if (bus.flush) begin
            for (int unsigned e = 0; e < ENTRIES; e++) begin
                entry_d[e].busy = 1'b0;
            end
        end
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (issue_fire) begin
            rr_d   = (sel_idx == IDX_W'(ENTRIES - 1)) ? '0 : sel_idx + IDX_W'(1);
            lock_d = 1'b0;
        end else if (issue_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end
        // Flush drops any in-flight offer but leaves fairness state alone.
        if (bus.flush) begin
            rr_d   = rr_q;
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned e = 0; e < ENTRIES; e++) begin
                entry_q[e] <= '0;
            end
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            for (int unsigned e = 0; e < ENTRIES; e++) begin
                entry_q[e] <= entry_d[e];
            end
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_trap_reservation_station.sv
// Scoreboard bench for trap_reservation_station (ENTRIES=4, RS_OFFSET=16).
module tb_trap_reservation_station;
    import trap_reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_reservation_station_if #(.RS_ID_WIDTH(5)) bus();

    trap_reservation_station #(
        .RS_ID_WIDTH (5),
        .ENTRIES     (4),
        .RS_OFFSET   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  to;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issue(input logic [4:0] id, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] to);
        exp_t e;
        e.id = id; e.a = a; e.b = b; e.to = to;
        sb.push_back(e);
    endtask

    task automatic take(input logic v1, input logic [31:0] a, input logic [4:0] t1,
                        input logic v2, input logic [31:0] b, input logic [4:0] t2,
                        input logic [4:0] to);
        bus.take_valid = 1'b1;
        bus.op1_valid  = v1; bus.op1_value = a; bus.op1_rs_id = t1;
        bus.op2_valid  = v2; bus.op2_value = b; bus.op2_rs_id = t2;
        bus.control.TO = to;
        tick();
        bus.take_valid = 1'b0;
        bus.op1_valid  = 1'b0;
        bus.op2_valid  = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
        bus.cdb_valid  = 1'b1;
        bus.cdb_rs_id  = tag;
        bus.cdb_result = val;
        tick();
        bus.cdb_valid  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 30 && sb.size() != 0; n++) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d expected 0", name, sb.size());
            sb.delete();
        end
        tick();
    endtask

    // Monitor: every accepted issue must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_issue: got id=%0d op1=%h op2=%h expected none",
                             bus.issue_rs_id, bus.issue_op1, bus.issue_op2);
                end else begin
                    e = sb.pop_front();
                    if (bus.issue_rs_id !== e.id || bus.issue_op1 !== e.a ||
                        bus.issue_op2 !== e.b || bus.issue_control.TO !== e.to) begin
                        bad++;
                        $display("FAIL issue: got id=%0d op1=%h op2=%h to=%b expected id=%0d op1=%h op2=%h to=%b",
                                 bus.issue_rs_id, bus.issue_op1, bus.issue_op2, bus.issue_control.TO,
                                 e.id, e.a, e.b, e.to);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.take_valid = 1'b0; bus.op1_valid = 1'b0; bus.op1_value = '0; bus.op1_rs_id = '0;
        bus.op2_valid = 1'b0; bus.op2_value = '0; bus.op2_rs_id = '0; bus.control = '0;
        bus.cdb_valid = 1'b0; bus.cdb_rs_id = '0; bus.cdb_result = '0; bus.flush = 1'b0;
        bus.issue_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_issue_valid", bus.issue_valid, 0);
        check("rst_take_ready",  bus.take_ready, 1);
        check("rst_rs_id",       bus.issue_rs_id, 0);
        check("rst_op1",         bus.issue_op1, 0);

        // Both operands ready: issue one cycle after the take.
        bus.issue_ready = 1'b1;
        expect_issue(5'd16, 32'd7, 32'd7, 5'b00100);
        take(1, 32'd7, 0, 1, 32'd7, 0, 5'b00100);
        check("t1_valid_next", bus.issue_valid, 1);
        drain("t1");
        check("t1_freed_take_ready", bus.take_ready, 1);
        check("t1_freed_valid", bus.issue_valid, 0);

        // op1 waits on tag 3; broadcast two cycles later.
        take(0, 0, 5'd3, 1, 32'd5, 0, 5'h1F);
        check("t2_wait0", bus.issue_valid, 0);
        tick();
        check("t2_wait1", bus.issue_valid, 0);
        expect_issue(5'd16, 32'hFFFF_FFFF, 32'd5, 5'h1F);
        cdb(5'd3, 32'hFFFF_FFFF);
        check("t2_valid_after_cdb", bus.issue_valid, 1);
        check("t2_op1", bus.issue_op1, 32'hFFFF_FFFF);
        drain("t2");

        // Same-cycle CDB bypass on op2.
        bus.cdb_valid = 1'b1; bus.cdb_rs_id = 5'd9; bus.cdb_result = 32'd42;
        expect_issue(5'd16, 32'd1, 32'd42, 5'h10);
        take(1, 32'd1, 0, 0, 0, 5'd9, 5'h10);
        bus.cdb_valid = 1'b0;
        check("t3_bypass_valid", bus.issue_valid, 1);
        drain("t3");

        // Fill all four; first offer locks on entry 0, rest follow 1,2,3.
        bus.issue_ready = 1'b0;
        expect_issue(5'd16, 32'd10, 32'd20, 5'd1);
        expect_issue(5'd17, 32'd11, 32'd21, 5'd2);
        expect_issue(5'd18, 32'd12, 32'd22, 5'd3);
        expect_issue(5'd19, 32'd13, 32'd23, 5'd4);
        take(1, 32'd10, 0, 1, 32'd20, 0, 5'd1);
        take(1, 32'd11, 0, 1, 32'd21, 0, 5'd2);
        take(1, 32'd12, 0, 1, 32'd22, 0, 5'd3);
        take(1, 32'd13, 0, 1, 32'd23, 0, 5'd4);
        check("t4_full", bus.take_ready, 0);
        check("t4_head_id", bus.issue_rs_id, 16);
        take(1, 32'd99, 0, 1, 32'd99, 0, 5'h1F);
        check("t4_still_full", bus.take_ready, 0);
        bus.issue_ready = 1'b1;
        tick();
        check("t4_ready_back", bus.take_ready, 1);
        drain("t4");

        // Stall with entry 2 selected while entry 0 becomes ready.
        bus.issue_ready = 1'b0;
        take(0, 0, 5'd6, 1, 32'd2, 0, 5'd1);
        take(0, 0, 5'd12, 1, 32'd3, 0, 5'd2);
        take(1, 32'hAAAA, 0, 1, 32'h5555, 0, 5'h0C);
        cdb(5'd6, 32'h66);
        for (int c = 0; c < 3; c++) begin
            check("t5_lock_id",  bus.issue_rs_id, 18);
            check("t5_lock_op1", bus.issue_op1, 32'hAAAA);
            check("t5_lock_op2", bus.issue_op2, 32'h5555);
            if (c < 2) tick();
        end
        expect_issue(5'd18, 32'hAAAA, 32'h5555, 5'h0C);
        expect_issue(5'd16, 32'h66, 32'd2, 5'd1);
        bus.issue_ready = 1'b1;
        drain("t5");
        bus.issue_ready = 1'b0;

        // Flush with a same-cycle take while three entries are busy.
        take(0, 0, 5'd13, 1, 32'd4, 0, 5'd1);
        take(0, 0, 5'd13, 1, 32'd5, 0, 5'd1);
        bus.flush = 1'b1;
        take(1, 32'd77, 0, 1, 32'd77, 0, 5'd3);
        bus.flush = 1'b0;
        check("t6_valid", bus.issue_valid, 0);
        check("t6_take_ready", bus.take_ready, 1);
        bus.issue_ready = 1'b1;
        cdb(5'd12, 32'h1);
        cdb(5'd13, 32'h2);
        tick();
        check("t6_no_stale_issue", bus.issue_valid, 0);
        bus.issue_ready = 1'b0;

        // All four entries free after flush; then async reset mid-handshake.
        for (int i = 0; i < 4; i++) begin
            check("t7_free", bus.take_ready, 1);
            take(1, 32'h100 + 32'(i), 0, 1, 32'h200 + 32'(i), 0, 5'h02);
        end
        check("t7_full", bus.take_ready, 0);
        check("t7_offer", bus.issue_valid, 1);
        bus.issue_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("t7_rst_valid", bus.issue_valid, 0);
        check("t7_rst_take_ready", bus.take_ready, 1);
        check("t7_rst_id", bus.issue_rs_id, 0);
        check("t7_rst_op1", bus.issue_op1, 0);
        check("t7_rst_op2", bus.issue_op2, 0);
        bus.issue_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("t7_post_valid", bus.issue_valid, 0);
        check("t7_post_take_ready", bus.take_ready, 1);
        check("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
